// File: rtl/mem_b.sv
// mem_b: B-operand staging memory for a DIM x DIM systolic multiplier.
// Takes one B row per enabled cycle and feeds each column into the array through
// a shift register of depth DIM+c, giving the diagonal wavefront skew.
// Optional build macro: MEMB_VALID_EN adds a per-stage valid bit and the Bvalid port.
// Note: rst_n is an asynchronous ACTIVE-HIGH reset despite its name.
module mem_b #(
  parameter int unsigned BITS_AB = 8,
  parameter int unsigned DIM     = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic signed [BITS_AB-1:0] Bin  [DIM],
  output logic signed [BITS_AB-1:0] Bout [DIM]
`ifdef MEMB_VALID_EN
  ,
  output logic        [DIM-1:0]     Bvalid
`endif
);

  for (genvar c = 0; c < DIM; c++) begin : g_col
    localparam int unsigned Depth = DIM + c;

    // Stage 0 occupies the low BITS_AB bits; the oldest stage sits at the top.
    logic [Depth*BITS_AB-1:0] sr_q;

    // Column shift register: load Bin[c] at stage 0 and advance on enable.
    always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
        sr_q <= '0;
      end else if (en) begin
        sr_q <= {sr_q[(Depth-1)*BITS_AB-1:0], Bin[c]};
      end
    end

    assign Bout[c] = sr_q[Depth*BITS_AB-1 -: BITS_AB];

`ifdef MEMB_VALID_EN
    logic [Depth-1:0] vld_q;

    // Valid bits travel alongside the data; every enabled edge inserts a 1.
    always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
        vld_q <= '0;
      end else if (en) begin
        vld_q <= {vld_q[Depth-2:0], 1'b1};
      end
    end

    assign Bvalid[c] = vld_q[Depth-1];
`endif
  end

endmodule

// File: tb/tb_mem_b.sv
// tb_mem_b: directed self-checking bench for mem_b (DIM=8, BITS_AB=8).
module tb_mem_b;

  localparam int unsigned Dim = 8;

  logic              clk;
  logic              rst_n;
  logic              en;
  logic signed [7:0] Bin  [Dim];
  logic signed [7:0] Bout [Dim];
`ifdef MEMB_VALID_EN
  logic [Dim-1:0]    Bvalid;
`endif

  int vectors;
  int miscompares;

  mem_b #(
    .BITS_AB(8),
    .DIM    (Dim)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .Bin   (Bin),
    .Bout  (Bout)
`ifdef MEMB_VALID_EN
    ,
    .Bvalid(Bvalid)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock edge; outputs are sampled 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_bin(input logic [7:0] v);
    for (int c = 0; c < Dim; c++) Bin[c] = v;
  endtask

  task automatic chk_all_zero(input string tag);
    for (int c = 0; c < Dim; c++) chk($sformatf("%s col%0d", tag, c), Bout[c], 8'h00);
  endtask

  // Row pattern for the skew test: distinct per (r, c), all negative.
  function automatic logic [7:0] brow(input int r, input int c);
    logic [7:0] v;
    v = 8'((r << 4) | c);
    return v ^ 8'h80;
  endfunction

  function automatic logic [7:0] skew_exp(input int e, input int c);
    int idx;
    idx = e - 8 - c;
    return (idx >= 0 && idx < 8) ? brow(idx, c) : 8'h00;
  endfunction

  initial begin
    vectors     = 0;
    miscompares = 0;
    en          = 1'b0;
    set_bin(8'h00);
    rst_n       = 1'b1;

    // Reset held across edges, then released.
    step();
    step();
    chk_all_zero("reset_held");
`ifdef MEMB_VALID_EN
    chk("reset_valid", Bvalid, 8'h00);
`endif
    rst_n = 1'b0;
    #1;

    // Latency: 5A loaded on columns 0 and 7 for one enabled edge.
    en      = 1'b1;
    set_bin(8'h00);
    Bin[0]  = 8'sh5A;
    Bin[7]  = 8'sh5A;
    step();
    set_bin(8'h00);
    for (int e = 2; e <= 16; e++) begin
      step();
      chk($sformatf("lat col0 edge%0d", e), Bout[0], (e == 8) ? 8'h5A : 8'h00);
      chk($sformatf("lat col7 edge%0d", e), Bout[7], (e == 15) ? 8'h5A : 8'h00);
`ifdef MEMB_VALID_EN
      chk($sformatf("lat vld0 edge%0d", e), {7'd0, Bvalid[0]}, {7'd0, e >= 8});
      chk($sformatf("lat vld7 edge%0d", e), {7'd0, Bvalid[7]}, {7'd0, e >= 15});
`endif
    end

    // Skew with a 3-cycle hold after edge 12.
    for (int e = 1; e <= 24; e++) begin
      en = 1'b1;
      for (int c = 0; c < Dim; c++) Bin[c] = (e <= 8) ? brow(e - 1, c) : 8'h00;
      step();
      for (int c = 0; c < Dim; c++)
        chk($sformatf("skew e%0d col%0d", e, c), Bout[c], skew_exp(e, c));
      if (e == 12) begin
        en = 1'b0;
        set_bin(8'hFF);
        for (int h = 0; h < 3; h++) begin
          step();
          for (int c = 0; c < Dim; c++)
            chk($sformatf("hold%0d col%0d", h, c), Bout[c], skew_exp(12, c));
        end
      end
    end

    // Mid-stream reset after 10 shifts of 0x80.
    en = 1'b1;
    set_bin(8'h80);
    for (int e = 1; e <= 10; e++) step();
    chk("pre_rst col0", Bout[0], 8'h80);
    chk("pre_rst col2", Bout[2], 8'h80);
    chk("pre_rst col3", Bout[3], 8'h00);
    rst_n = 1'b1;
    #1;
    chk_all_zero("rst_async");
`ifdef MEMB_VALID_EN
    chk("rst_async_valid", Bvalid, 8'h00);
`endif
    step();
    chk_all_zero("rst_edge");
    rst_n = 1'b0;

    // Fresh signed load after release: 0x80 on one edge.
    set_bin(8'h80);
    step();
    set_bin(8'h00);
    for (int e = 2; e <= 15; e++) begin
      step();
      chk($sformatf("sgn col0 edge%0d", e), Bout[0], (e == 8) ? 8'h80 : 8'h00);
      chk($sformatf("sgn col7 edge%0d", e), Bout[7], (e == 15) ? 8'h80 : 8'h00);
`ifdef MEMB_VALID_EN
      chk($sformatf("sgn vld7 edge%0d", e), {7'd0, Bvalid[7]}, {7'd0, e >= 15});
`endif
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
